// File: rtl/rv32i_trace_pkg.sv
// Shared trace-path definitions: UART transmitter FSM encoding and framing constants.
package rv32i_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BITS_PER_BYTE  = 8;

endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous DEPTH x W word FIFO with a head-of-queue read port.
//  clk, reset   : clock, async active-high reset (pointers and count only)
//  push, din    : write request/data; accepted when not full, or when full with a same-edge pop
//  pop          : remove head (ignored when empty)
//  dout         : current head word (combinational)
//  full, empty  : occupancy flags
//  count        : words held, 0..DEPTH
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign pop_ok  = pop && !empty;
  // a pop on the same edge frees the slot the push lands in
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/wb_trace_uart_tx.sv
// Writeback trace serialiser: buffers qualified WBout words and sends each as four
// UART 8N1 frames, LSB byte first, back-to-back with no idle gap while words remain.
//  clk, reset  : clock, async active-high reset (drops in-flight and buffered words)
//  wb_valid    : writeback qualifier, wb_data captured on each edge where high
//  wb_data     : writeback value
//  tx          : registered serial line, idle high
//  busy        : a word is being serialised
//  overflow    : sticky, a word was dropped on a full FIFO
//  fifo_count  : words currently buffered
module wb_trace_uart_tx
  import rv32i_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_valid,
  input  logic [31:0]            wb_data,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [31:0]   shreg;
  logic [31:0]   head;
  logic          full, empty;
  logic          baud_end, last_stop, pop;

  assign baud_end  = baud_cnt == BW'(CLKS_PER_BIT - 1);
  assign last_stop = (state == ST_STOP) && baud_end && (byte_idx == 2'(BYTES_PER_WORD - 1));
  // load the next word from idle, or seamlessly at the end of the final stop bit
  assign pop       = !empty && ((state == ST_IDLE) || last_stop);
  assign busy      = state != ST_IDLE;

  wb_trace_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wb_valid),
    .din   (wb_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (wb_valid && full && !pop) overflow <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
    end else if (pop) begin
      state    <= ST_START;
      tx       <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= head;
    end else begin
      case (state)
        ST_IDLE: tx <= 1'b1;
        ST_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= ST_DATA;
            tx       <= shreg[0];
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            // shift every bit so the next byte sits at bit 0 after eight shifts
            shreg    <= shreg >> 1;
            if (bit_idx == 3'(BITS_PER_BYTE - 1)) begin
              bit_idx <= '0;
              state   <= ST_STOP;
              tx      <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx != 2'(BYTES_PER_WORD - 1)) begin
              byte_idx <= byte_idx + 1'b1;
              state    <= ST_START;
              tx       <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx    <= 1'b1;
            end
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_uart_tx.sv
// Directed bench for wb_trace_uart_tx: a fast instance (4 clocks/bit, depth 4) with a
// background UART decoder, plus a 434 clocks/bit instance checked for bit-time spacing.
module tb_wb_trace_uart_tx;

  localparam int CPB  = 4;
  localparam int CPB2 = 434;
  localparam int DEPTH = 4;
  localparam int CW   = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wb_valid = 1'b0, wb_valid2 = 1'b0;
  logic [31:0]   wb_data = '0, wb_data2 = '0;
  logic          tx, busy, overflow, tx2, busy2, overflow2;
  logic [CW-1:0] fifo_count, fifo_count2;

  wb_trace_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst), .wb_valid(wb_valid), .wb_data(wb_data),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  wb_trace_uart_tx #(.CLKS_PER_BIT(CPB2), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(rst), .wb_valid(wb_valid2), .wb_data(wb_data2),
    .tx(tx2), .busy(busy2), .overflow(overflow2), .fifo_count(fifo_count2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // UART decoder for the fast instance: sample mid-bit, log byte and start cycle
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         mon_ferr = 0, mon_t = 0, mon_k = 0, mon_start = 0;
  bit         mon_act = 1'b0;
  logic [7:0] mon_sh = '0;

  initial forever begin
    @(posedge clk); #1;
    if (rst) mon_act = 1'b0;
    else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act = 1'b1; mon_t = 0; mon_start = cyc;
      end
    end else begin
      mon_t++;
      if (mon_t % CPB == CPB / 2) begin
        mon_k = mon_t / CPB;
        if (mon_k == 0) begin
          if (tx !== 1'b0) mon_ferr++;
        end else if (mon_k <= 8) mon_sh[mon_k-1] = tx;
        else begin
          if (tx !== 1'b1) mon_ferr++;
          rx_q.push_back(mon_sh);
          rx_t.push_back(mon_start);
          mon_act = 1'b0;
        end
      end
    end
  end

  // spacing monitor for the slow instance
  logic tx2_prev = 1'b1;
  bit   sp_have = 1'b0;
  int   sp_last = 0, sp_err = 0, sp_ntr = 0;

  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      sp_have = 1'b0; sp_ntr = 0; tx2_prev = tx2;
    end else if (tx2 !== tx2_prev) begin
      if (sp_have && ((cyc - sp_last) % CPB2 != 0)) sp_err++;
      sp_have = 1'b1; sp_last = cyc; sp_ntr++;
      tx2_prev = tx2;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic wait_idle(input bit sel, input int budget, output int t_end);
    int n = 0;
    while ((sel ? busy2 : busy) && n < budget) begin
      step();
      n++;
    end
    if (sel ? busy2 : busy) chk("idle_timeout", 1, 0);
    t_end = cyc;
  endtask

  function automatic logic [31:0] word_at(input int i);
    if (rx_q.size() < 4 * i + 4) return 32'hxxxx_xxxx;
    return {rx_q[4*i+3], rx_q[4*i+2], rx_q[4*i+1], rx_q[4*i]};
  endfunction

  int s, te, gaps, l;

  initial begin
    // reset state
    step(2);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", fifo_count, 0);
    do_reset();

    // 1: single word
    wb_valid = 1'b1; wb_data = 32'hA5A5_0F0F;
    step();
    wb_valid = 1'b0;
    chk("t1_cnt_push", fifo_count, 1);
    chk("t1_tx_idle", tx, 1);
    step();
    chk("t1_start_tx", tx, 0);
    chk("t1_busy", busy, 1);
    chk("t1_cnt_pop", fifo_count, 0);
    s = cyc;
    wait_idle(0, 400, te);
    chk("t1_busy_len", te - s, 160);
    chk("t1_nbytes", rx_q.size(), 4);
    chk("t1_word", word_at(0), 32'hA5A5_0F0F);
    chk("t1_tx_end", tx, 1);
    chk("t1_cnt_end", fifo_count, 0);

    // 2: back-to-back words, contiguous frames
    do_reset();
    wb_valid = 1'b1; wb_data = 32'h0000_0001;
    step();
    wb_data = 32'hFFFF_FFFF;
    step();
    wb_valid = 1'b0;
    chk("t2_busy", busy, 1);
    s = cyc;
    wait_idle(0, 800, te);
    chk("t2_busy_len", te - s, 320);
    chk("t2_nbytes", rx_q.size(), 8);
    chk("t2_word0", word_at(0), 32'h0000_0001);
    chk("t2_word1", word_at(1), 32'hFFFF_FFFF);
    gaps = 0;
    for (int i = 1; i < rx_t.size(); i++) if (rx_t[i] - rx_t[i-1] != 10 * CPB) gaps++;
    chk("t2_gaps", gaps, 0);

    // 3: overflow on the sixth consecutive push
    do_reset();
    wb_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      wb_data = i;
      step();
      chk($sformatf("t3_ovf_%0d", i), overflow, 64'(i == 6));
    end
    wb_valid = 1'b0;
    wait_idle(0, 1200, te);
    chk("t3_nbytes", rx_q.size(), 20);
    for (int i = 0; i < 5; i++) chk($sformatf("t3_word%0d", i), word_at(i), i + 1);
    chk("t3_ovf_sticky", overflow, 1);
    chk("t3_cnt_end", fifo_count, 0);

    // 4: full FIFO, push on the same edge as a pop
    do_reset();
    wb_valid = 1'b1; wb_data = 32'd10;
    step();
    wb_data = 32'd11;
    step();
    l = cyc;
    chk("t4_busy", busy, 1);
    for (int i = 12; i <= 14; i++) begin
      wb_data = i;
      step();
    end
    wb_valid = 1'b0;
    chk("t4_full", fifo_count, 4);
    while (cyc < l + 159) step();
    chk("t4_pre_pop_cnt", fifo_count, 4);
    wb_valid = 1'b1; wb_data = 32'd15;
    step();
    wb_valid = 1'b0;
    chk("t4_cnt_same", fifo_count, 4);
    chk("t4_ovf", overflow, 0);
    wait_idle(0, 1500, te);
    chk("t4_nbytes", rx_q.size(), 24);
    for (int i = 0; i < 6; i++) chk($sformatf("t4_word%0d", i), word_at(i), 10 + i);
    chk("t4_ovf_end", overflow, 0);

    // 5: async reset during data bit 3 of byte 1
    do_reset();
    wb_valid = 1'b1; wb_data = 32'hCAFE_00AA;
    step();
    wb_data = 32'h1111_1111;
    step();
    wb_valid = 1'b0;
    l = cyc;
    while (cyc < l + 57) step();
    chk("t5_pre_tx", tx, 0);
    chk("t5_pre_cnt", fifo_count, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_tx", tx, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cnt", fifo_count, 0);
    step(2);
    rst = 1'b0;
    step();
    rx_q.delete();
    rx_t.delete();
    wb_valid = 1'b1; wb_data = 32'h1234_5678;
    step();
    wb_valid = 1'b0;
    step(3);
    wait_idle(0, 400, te);
    chk("t5_nbytes", rx_q.size(), 4);
    chk("t5_word", word_at(0), 32'h1234_5678);

    // 6: 434 clocks per bit
    wb_valid2 = 1'b1; wb_data2 = 32'h5A3C_96F0;
    step();
    wb_valid2 = 1'b0;
    step();
    chk("t6_busy", busy2, 1);
    s = cyc;
    wait_idle(1, 18000, te);
    chk("t6_busy_len", te - s, 40 * CPB2);
    chk("t6_spacing", sp_err, 0);
    chk("t6_has_edges", 64'(sp_ntr >= 2), 1);
    chk("t6_tx_end", tx2, 1);

    chk("frame_errors", mon_ferr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
